// File: rtl/arb_mux21_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
// The state encoding is fixed so that IDLE reads back as zero.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic SEL_REQ0 = 1'b0;

endpackage

// File: rtl/arb_mux21_if.sv
// Stream bundle for arb_mux21: two requester streams, one muxed output stream
// and the arbiter status flags.
interface arb_mux21_if #(
    parameter int WIDTH = 8
);

    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_last;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_last;
    logic             req1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;
    logic             sel;
    logic             busy;
    logic             abort;

    // Producers and the downstream consumer together form the master side.
    modport master (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_data, out_last,
        input  sel, busy, abort
    );

    modport slave (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_data, out_last,
        output sel, busy, abort
    );

endinterface

// File: rtl/mux21_w.sv
// Parameterised WIDTH-bit 2:1 datapath mux: y = a when sel = 0, b when sel = 1.
module mux21_w #(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/arb_mux21.sv
// Round-robin arbiter for two valid/ready/last streams sharing one 2:1 mux path.
// A grant is held until the last beat is accepted or a mid-packet stall times out.
module arb_mux21
    import arb_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    arb_mux21_if.slave     bus
);

    // The stall that would bring the count to TIMEOUT revokes the grant instead.
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic             sel_q, sel_nxt;
    logic             ptr, ptr_nxt;
    logic             busy_q;
    logic             abort_q, abort_nxt;
    logic [CNT_W-1:0] stall, stall_nxt;

    logic             granted;
    logic             gnt_valid;
    logic             xfer_last;
    logic             grant0;
    logic             grant1;
    logic [WIDTH-1:0] mux_data;
    logic             mux_last;

    mux21_w #(.WIDTH(WIDTH)) u_data_mux (
        .sel (sel_q),
        .a   (bus.req0_data),
        .b   (bus.req1_data),
        .y   (mux_data)
    );

    mux21_w #(.WIDTH(1)) u_last_mux (
        .sel (sel_q),
        .a   (bus.req0_last),
        .b   (bus.req1_last),
        .y   (mux_last)
    );

    assign granted   = (state != IDLE);
    assign gnt_valid = granted & (sel_q ? bus.req1_valid : bus.req0_valid);
    assign xfer_last = gnt_valid & bus.out_ready & mux_last;

    assign bus.out_valid  = gnt_valid;
    assign bus.out_data   = granted ? mux_data : '0;
    assign bus.out_last   = granted & mux_last;
    assign bus.req0_ready = (state == GNT0) & bus.out_ready;
    assign bus.req1_ready = (state == GNT1) & bus.out_ready;
    assign bus.sel        = sel_q;
    assign bus.busy       = busy_q;
    assign bus.abort      = abort_q;

    // On a tie the requester that was not served last wins.
    assign grant0 = bus.req0_valid & (~bus.req1_valid | (ptr != SEL_REQ0));
    assign grant1 = bus.req1_valid & (~bus.req0_valid | (ptr == SEL_REQ0));

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        ptr_nxt   = ptr;
        stall_nxt = stall;
        abort_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant0) begin
                    state_nxt = GNT0;
                    sel_nxt   = SEL_REQ0;
                    ptr_nxt   = SEL_REQ0;
                    stall_nxt = '0;
                end else if (grant1) begin
                    state_nxt = GNT1;
                    sel_nxt   = ~SEL_REQ0;
                    ptr_nxt   = ~SEL_REQ0;
                    stall_nxt = '0;
                end
            end
            GNT0, GNT1: begin
                if (xfer_last) begin
                    state_nxt = IDLE;
                    stall_nxt = '0;
                end else if (gnt_valid) begin
                    stall_nxt = '0;
                end else if (stall == STALL_MAX) begin
                    state_nxt = IDLE;
                    stall_nxt = '0;
                    abort_nxt = 1'b1;
                end else begin
                    stall_nxt = stall + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                stall_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_q   <= SEL_REQ0;
            ptr     <= ~SEL_REQ0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
            stall   <= '0;
        end else begin
            state   <= state_nxt;
            sel_q   <= sel_nxt;
            ptr     <= ptr_nxt;
            busy_q  <= (state_nxt != IDLE);
            abort_q <= abort_nxt;
            stall   <= stall_nxt;
        end
    end

endmodule
